// File: rtl/jk_updown_counter_pkg.sv
// Shared encodings for the JK up/down counter slice.
//   DIR_*  : value of the `up` input for each count direction.
//   JK_*   : {J,K} input code of a JK cell. The cell decode and the counter
//            excitation both use these so the two sides cannot drift apart.
package jk_updown_counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // {J,K} that moves a cell from cur to nxt without ever using toggle.
   function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
      return {~cur & nxt, cur & ~nxt};
   endfunction

endpackage

// File: rtl/jk_updown_counter_jk_ff_cell.sv
// jk_ff_cell: single positive-edge JK flip-flop.
//   clk : clock
//   rst : asynchronous active-low reset, clears q to 0
//   j,k : JK inputs (hold / reset / set / toggle)
//   q   : stored bit
module jk_ff_cell
   import jk_updown_counter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            JK_HOLD:  q <= q;
            JK_RESET: q <= 1'b0;
            JK_SET:   q <= 1'b1;
            default:  q <= ~q;   // JK_TOGGLE
         endcase
      end
   end

endmodule

// File: rtl/jk_updown_counter.sv
// jk_updown_counter: synchronous modulo-MODULUS up/down counter whose state
// bits live in JK flip-flop cells driven by excitation logic.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset (q=0, wrap_flag=0)
//   en        : count enable
//   up        : 1 counts up, 0 counts down
//   load      : parallel load strobe, priority over en
//   din       : load value, saturated to MODULUS-1 when out of range
//   clr_wrap  : synchronous clear of wrap_flag (a coincident wrap wins)
//   q         : current count
//   tc        : terminal count, combinational, high the cycle before a wrap
//   wrap_flag : sticky, set on every counted wrap
module jk_updown_counter
   import jk_updown_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             clr_wrap,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap_flag
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] j, k;
   logic             in_range;
   logic             at_top, at_bot;

   // MAX is used instead of MODULUS so MODULUS == 2**WIDTH still fits.
   assign in_range = (q <= MAX);
   assign at_top   = (q == MAX);
   assign at_bot   = (q == '0);

   // at_top/at_bot can only be true in range, so tc is 0 for stray values.
   assign tc = en & ~load & (((up == DIR_UP) & at_top) | ((up == DIR_DOWN) & at_bot));

   always_comb begin
      nxt = q;
      if (load) begin
         nxt = (din > MAX) ? MAX : din;
      end else if (en) begin
         if (!in_range)        nxt = '0;   // recover from an illegal state
         else if (up == DIR_UP) nxt = at_top ? '0  : q + 1'b1;
         else                   nxt = at_bot ? MAX : q - 1'b1;
      end
   end

   // State bits are only ever written through their JK cells.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign {j[i], k[i]} = jk_excite(q[i], nxt[i]);

      jk_ff_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (j[i]),
         .k   (k[i]),
         .q   (q[i])
      );
   end

   // tc marks exactly the edges that wrap; set takes priority over clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          wrap_flag <= 1'b0;
      else if (tc)       wrap_flag <= 1'b1;
      else if (clr_wrap) wrap_flag <= 1'b0;
   end

endmodule

// File: tb/tb_jk_updown_counter.sv
module tb_jk_updown_counter;

   localparam int WIDTH   = 4;
   localparam int MODULUS = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             en, up, load, clr_wrap;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] q;
   logic             tc, wrap_flag;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state, plain integers.
   int m_q    = 0;
   int m_wrap = 0;

   jk_updown_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .up        (up),
      .load      (load),
      .din       (din),
      .clr_wrap  (clr_wrap),
      .q         (q),
      .tc        (tc),
      .wrap_flag (wrap_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
   endtask

   // A wrap is a counted step that leaves the top (up) or the bottom (down).
   function automatic int m_wraps();
      if (load || !en || m_q >= MODULUS) return 0;
      return (up && m_q == MODULUS - 1) || (!up && m_q == 0);
   endfunction

   function automatic void m_step();
      int w;
      w = m_wraps();
      if (load)                m_q = (int'(din) < MODULUS) ? int'(din) : MODULUS - 1;
      else if (en && up)       m_q = (m_q + 1) % MODULUS;
      else if (en)             m_q = (m_q + MODULUS - 1) % MODULUS;
      if (w != 0)        m_wrap = 1;
      else if (clr_wrap) m_wrap = 0;
   endfunction

   // Inputs are set while mid-cycle; tc checked before the edge, q after it.
   task automatic cycle();
      @(negedge clk);
      chk("tc", int'(tc), m_wraps());
      @(posedge clk);
      m_step();
      #1;
      chk("q", int'(q), m_q);
      chk("wrap_flag", int'(wrap_flag), m_wrap);
   endtask

   task automatic set_in(input logic l, input logic e, input logic u,
                         input int d, input logic c);
      load = l; en = e; up = u; din = WIDTH'(d); clr_wrap = c;
   endtask

   // Asserts reset mid-cycle and expects outputs to clear before any edge.
   task automatic async_reset();
      rst = 1'b0;
      #2;
      m_q = 0; m_wrap = 0;
      chk("rst_q", int'(q), 0);
      chk("rst_wrap", int'(wrap_flag), 0);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      set_in(0, 1, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("reset_q", int'(q), 0);
      chk("reset_wrap", int'(wrap_flag), 0);
      chk("reset_tc", int'(tc), 1);          // en & ~up
      rst = 1'b1;

      // Reach 7, then reset mid-cycle; first counted edge gives 1.
      set_in(1, 0, 1, 7, 0); cycle();
      chk("at7", int'(q), 7);
      async_reset();
      set_in(0, 1, 1, 0, 0); cycle();
      chk("first_after_rst", int'(q), 1);

      // Up wrap from 0 for 12 edges.
      async_reset();
      set_in(0, 1, 1, 0, 0);
      for (int i = 0; i < 12; i++) cycle();
      chk("up_end", int'(q), 2);
      chk("up_wrap", int'(wrap_flag), 1);

      // Down wrap from 1.
      async_reset();
      set_in(1, 0, 0, 1, 0); cycle();
      set_in(0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle();
      chk("down_end", int'(q), 8);

      // Load priority and saturation; tc must stay low during load.
      set_in(1, 1, 0, 4, 1); cycle();
      chk("load4", int'(q), 4);
      set_in(1, 1, 1, 13, 0); cycle();
      chk("load_sat", int'(q), 9);
      chk("load_nowrap", int'(wrap_flag), 0);
      set_in(1, 1, 1, 9, 0);
      @(negedge clk);
      chk("tc_load", int'(tc), 0);
      cycle();

      // Hold then alternating direction.
      set_in(1, 0, 1, 6, 0); cycle();
      set_in(0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cycle();
      chk("hold", int'(q), 6);
      for (int i = 0; i < 4; i++) begin
         set_in(0, 1, (i % 2 == 0), 0, 0); cycle();
      end
      chk("dir_toggle", int'(q), 6);

      // Clear colliding with a wrap, then a clean clear.
      set_in(1, 0, 1, 9, 0); cycle();
      set_in(0, 1, 1, 0, 1); cycle();
      chk("collide_set_wins", int'(wrap_flag), 1);
      set_in(0, 1, 1, 0, 1); cycle();
      chk("clear", int'(wrap_flag), 0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) async_reset();
         set_in($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                1'($urandom), int'($urandom_range(0, 15)),
                $urandom_range(0, 7) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
